// File: rtl/dl_fpu_issue_ctrl_pkg.sv
// Shared types and encoding constants for the DLFloat16 FPU issue controller
// and its instruction encoder.
package dl_fpu_pkg;

   typedef enum logic [4:0] {
      ADD     = 5'd0,
      SUB     = 5'd1,
      MUL     = 5'd2,
      DIV     = 5'd3,
      SQRT    = 5'd4,
      MADD    = 5'd5,
      MSUB    = 5'd6,
      SGNJ    = 5'd7,
      SGNJN   = 5'd8,
      SGNJX   = 5'd9,
      MIN     = 5'd10,
      MAX     = 5'd11,
      EQ      = 5'd12,
      LT      = 5'd13,
      LE      = 5'd14,
      CVT_I2F = 5'd15,
      CVT_F2I = 5'd16
   } fpu_op_e;

   localparam logic [4:0] F5_ADD     = 5'b00000;
   localparam logic [4:0] F5_SUB     = 5'b00001;
   localparam logic [4:0] F5_MUL     = 5'b00010;
   localparam logic [4:0] F5_DIV     = 5'b00011;
   localparam logic [4:0] F5_SQRT    = 5'b01011;
   localparam logic [4:0] F5_SGNJ    = 5'b00100;
   localparam logic [4:0] F5_MINMAX  = 5'b00101;
   localparam logic [4:0] F5_CMP     = 5'b10100;
   localparam logic [4:0] F5_CVT_I2F = 5'b11010;
   localparam logic [4:0] F5_CVT_F2I = 5'b11000;

   localparam logic [6:0] OPC_OP_FP = 7'b1010011;
   localparam logic [6:0] OPC_MADD  = 7'b1000011;
   localparam logic [6:0] OPC_MSUB  = 7'b1000111;
   localparam logic [1:0] FMT_DL16  = 2'b10;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;
   localparam logic [2:0] RM_DYN = 3'b111;

   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   localparam logic [31:0] CANON_NAN = 32'h0000_7FFF;

   // FP operands live in the low half; the upper half is forced to zero.
   function automatic logic [31:0] fp_operand(input logic [31:0] x);
      return {16'h0000, x[15:0]};
   endfunction

   function automatic logic op_uses_b(input logic [4:0] op);
      return !(op == SQRT || op == CVT_I2F || op == CVT_F2I);
   endfunction

   function automatic logic op_uses_c(input logic [4:0] op);
      return (op == MADD || op == MSUB);
   endfunction

endpackage

// File: rtl/dl_fpu_issue_ctrl_if.sv
// Request/response and FPU-side bus of the DLFloat16 issue controller.
interface dl_fpu_issue_ctrl_if #(
   parameter int TAG_W = 4
);
   import dl_fpu_pkg::*;

   // Valid/ready: a beat transfers on a rising edge where valid && ready; once
   // raised, valid and its payload hold until that edge.
   logic             req_valid;
   logic             req_ready;
   logic [4:0]       req_op;
   logic [2:0]       req_rm;
   logic [31:0]      req_a;
   logic [31:0]      req_b;
   logic [31:0]      req_c;
   logic [TAG_W-1:0] req_tag;
   logic [2:0]       frm;
   logic             fflags_clr;
   logic [31:0]      fpu_instr;
   logic [31:0]      fpu_op1;
   logic [31:0]      fpu_op2;
   logic [31:0]      fpu_op3;
   logic [31:0]      fpu_result;
   logic [4:0]       fpu_excep;
   logic             resp_valid;
   logic             resp_ready;
   logic [31:0]      resp_result;
   logic [4:0]       resp_flags;
   logic             resp_illegal;
   logic [TAG_W-1:0] resp_tag;
   logic [4:0]       fflags;

   modport slave (
      input  req_valid, req_op, req_rm, req_a, req_b, req_c, req_tag, frm, fflags_clr,
             fpu_result, fpu_excep, resp_ready,
      output req_ready, fpu_instr, fpu_op1, fpu_op2, fpu_op3,
             resp_valid, resp_result, resp_flags, resp_illegal, resp_tag, fflags
   );

   modport master (
      output req_valid, req_op, req_rm, req_a, req_b, req_c, req_tag, frm, fflags_clr,
             fpu_result, fpu_excep, resp_ready,
      input  req_ready, fpu_instr, fpu_op1, fpu_op2, fpu_op3,
             resp_valid, resp_result, resp_flags, resp_illegal, resp_tag, fflags
   );

endinterface

// File: rtl/dl_fpu_issue_ctrl_instr_enc.sv
// Combinational encoder: abstract op + resolved rounding mode -> OP-FP / R4
// instruction word, plus an illegal flag for unencodable requests.
module dl_fpu_instr_enc
   import dl_fpu_pkg::*;
(
   input  logic [4:0]  op_i,
   input  logic [2:0]  rm_i,
   output logic [31:0] instr_o,
   output logic        illegal_o
);

   logic [4:0] funct5;
   logic [2:0] sub_sel;
   logic       is_r4;
   logic [6:0] r4_opc;

   always_comb begin
      funct5  = F5_ADD;
      sub_sel = rm_i;
      is_r4   = 1'b0;
      r4_opc  = OPC_MADD;
      case (op_i)
         ADD:     funct5 = F5_ADD;
         SUB:     funct5 = F5_SUB;
         MUL:     funct5 = F5_MUL;
         DIV:     funct5 = F5_DIV;
         SQRT:    funct5 = F5_SQRT;
         MADD:    begin is_r4 = 1'b1; r4_opc = OPC_MADD; end
         MSUB:    begin is_r4 = 1'b1; r4_opc = OPC_MSUB; end
         SGNJ:    begin funct5 = F5_SGNJ;   sub_sel = 3'b000; end
         SGNJN:   begin funct5 = F5_SGNJ;   sub_sel = 3'b001; end
         SGNJX:   begin funct5 = F5_SGNJ;   sub_sel = 3'b010; end
         MIN:     begin funct5 = F5_MINMAX; sub_sel = 3'b000; end
         MAX:     begin funct5 = F5_MINMAX; sub_sel = 3'b001; end
         EQ:      begin funct5 = F5_CMP;    sub_sel = 3'b010; end
         LT:      begin funct5 = F5_CMP;    sub_sel = 3'b001; end
         LE:      begin funct5 = F5_CMP;    sub_sel = 3'b000; end
         CVT_I2F: funct5 = F5_CVT_I2F;
         CVT_F2I: funct5 = F5_CVT_F2I;
         default: funct5 = F5_ADD;
      endcase
      // R4 form carries rs3=3 where R-type carries funct5.
      if (is_r4)
         instr_o = {5'd3, FMT_DL16, 5'd2, 5'd1, rm_i, 5'd0, r4_opc};
      else
         instr_o = {funct5, FMT_DL16, 5'd2, 5'd1, sub_sel, 5'd0, OPC_OP_FP};
   end

   // rm 111 after resolution means frm itself was DYN, which is also reserved.
   assign illegal_o = (op_i > CVT_F2I) || (rm_i == 3'b101) || (rm_i == 3'b110) ||
                      (rm_i == RM_DYN);

endmodule

// File: rtl/dl_fpu_issue_ctrl.sv
// DLFloat16 FPU issue controller: encodes requests, waits the FPU latency and
// returns tagged results. Optional macro DL_FPU_CANON_NAN_EN canonicalises invalid results.
module dl_fpu_issue_ctrl
   import dl_fpu_pkg::*;
#(
   parameter int LATENCY = 1,
   parameter int TAG_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   dl_fpu_issue_ctrl_if.slave bus,
   output logic [1:0]         state_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [3:0] LAT4    = 4'(LATENCY);

   logic [1:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [31:0]      instr_q, instr_d, op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
   logic             resp_valid_q, resp_valid_d, resp_illegal_q, resp_illegal_d;
   logic [31:0]      resp_result_q, resp_result_d;
   logic [4:0]       resp_flags_q, resp_flags_d, fflags_q, fflags_d;
   logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

   logic [2:0]  rm_res;
   logic [31:0] enc_instr, cap_result;
   logic        enc_illegal;

   assign rm_res = (bus.req_rm == RM_DYN) ? bus.frm : bus.req_rm;

   dl_fpu_instr_enc u_enc (
      .op_i      (bus.req_op),
      .rm_i      (rm_res),
      .instr_o   (enc_instr),
      .illegal_o (enc_illegal)
   );

   always_comb begin
      cap_result = bus.fpu_result;
`ifdef DL_FPU_CANON_NAN_EN
      if (bus.fpu_excep[FLAG_NV]) cap_result = CANON_NAN;
`endif
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      instr_d        = instr_q;
      op1_d          = op1_q;
      op2_d          = op2_q;
      op3_d          = op3_q;
      resp_valid_d   = resp_valid_q;
      resp_result_d  = resp_result_q;
      resp_flags_d   = resp_flags_q;
      resp_illegal_d = resp_illegal_q;
      resp_tag_d     = resp_tag_q;
      fflags_d       = bus.fflags_clr ? 5'b0 : fflags_q;
      case (state_q)
         ST_IDLE: if (bus.req_valid) begin
            resp_tag_d = bus.req_tag;
            if (enc_illegal) begin
               state_d        = ST_RESP;
               resp_valid_d   = 1'b1;
               resp_result_d  = '0;
               resp_flags_d   = '0;
               resp_illegal_d = 1'b1;
            end else begin
               state_d = ST_EXEC;
               cnt_d   = LAT4;
               instr_d = enc_instr;
               op1_d   = (bus.req_op == CVT_I2F) ? bus.req_a : fp_operand(bus.req_a);
               op2_d   = op_uses_b(bus.req_op) ? fp_operand(bus.req_b) : '0;
               op3_d   = op_uses_c(bus.req_op) ? fp_operand(bus.req_c) : '0;
            end
         end
         // Counter runs LATENCY..0; capture on the edge after it sits at 0,
         // giving a response LATENCY+1 edges after the accept.
         ST_EXEC: if (cnt_q == 4'd0) begin
            state_d        = ST_RESP;
            resp_valid_d   = 1'b1;
            resp_result_d  = cap_result;
            resp_flags_d   = bus.fpu_excep;
            resp_illegal_d = 1'b0;
            fflags_d       = fflags_d | bus.fpu_excep;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
         ST_RESP: if (bus.resp_ready) begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         instr_q        <= '0;
         op1_q          <= '0;
         op2_q          <= '0;
         op3_q          <= '0;
         resp_valid_q   <= 1'b0;
         resp_result_q  <= '0;
         resp_flags_q   <= '0;
         resp_illegal_q <= 1'b0;
         resp_tag_q     <= '0;
         fflags_q       <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         instr_q        <= instr_d;
         op1_q          <= op1_d;
         op2_q          <= op2_d;
         op3_q          <= op3_d;
         resp_valid_q   <= resp_valid_d;
         resp_result_q  <= resp_result_d;
         resp_flags_q   <= resp_flags_d;
         resp_illegal_q <= resp_illegal_d;
         resp_tag_q     <= resp_tag_d;
         fflags_q       <= fflags_d;
      end
   end

   assign bus.req_ready    = (state_q == ST_IDLE);
   assign bus.fpu_instr    = instr_q;
   assign bus.fpu_op1      = op1_q;
   assign bus.fpu_op2      = op2_q;
   assign bus.fpu_op3      = op3_q;
   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_result  = resp_result_q;
   assign bus.resp_flags   = resp_flags_q;
   assign bus.resp_illegal = resp_illegal_q;
   assign bus.resp_tag     = resp_tag_q;
   assign bus.fflags       = fflags_q;
   assign state_o          = state_q;

endmodule

// File: tb/tb_dl_fpu_issue_ctrl.sv
// Scoreboard bench for dl_fpu_issue_ctrl: directed requests with hand-encoded
// instruction words; a monitor checks every response handshake against exp_q.
module tb_dl_fpu_issue_ctrl;
   import dl_fpu_pkg::*;

   localparam int LAT = 1;
   localparam int TW  = 4;
   localparam int EW  = 32 + 5 + 1 + TW;
`ifdef DL_FPU_CANON_NAN_EN
   localparam logic [31:0] SQRT_EXP = 32'h0000_7FFF;
`else
   localparam logic [31:0] SQRT_EXP = 32'h0000_1234;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] state;

   dl_fpu_issue_ctrl_if #(.TAG_W(TW)) bus ();

   dl_fpu_issue_ctrl #(.LATENCY(LAT), .TAG_W(TW)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave),
      .state_o (state)
   );

   always #5 clk = ~clk;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   logic [EW-1:0] exp_q[$];
   logic [31:0]   last_instr = 32'h0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every response handshake pops one expected entry.
   always @(negedge clk) begin : monitor
      logic [EW-1:0] e;
      if (!rst && bus.resp_valid && bus.resp_ready) begin
         if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL resp_unexpected: got response tag %0h, expected none", bus.resp_tag);
         end else begin
            e = exp_q.pop_front();
            check("resp_result",  bus.resp_result,  e[EW-1 -: 32]);
            check("resp_flags",   bus.resp_flags,   e[TW+5 -: 5]);
            check("resp_illegal", bus.resp_illegal, e[TW]);
            check("resp_tag",     bus.resp_tag,     e[TW-1:0]);
         end
      end
   end

   task automatic issue(input logic [4:0] op, input logic [2:0] rm,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [TW-1:0] tag, input logic [31:0] fres, input logic [4:0] fexc,
                        input logic [31:0] exp_instr, input logic [31:0] exp_op1,
                        input logic [31:0] exp_op2, input logic [31:0] exp_op3,
                        input logic ill, input logic [31:0] exp_res, input logic [4:0] exp_fflags,
                        input int bp, input logic clr_cap);
      int n;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_op     = op;
      bus.req_rm     = rm;
      bus.req_a      = a;
      bus.req_b      = b;
      bus.req_c      = c;
      bus.req_tag    = tag;
      bus.fpu_result = fres;
      bus.fpu_excep  = fexc;
      bus.resp_ready = (bp == 0);
      check("req_ready_idle", bus.req_ready, 1'b1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      exp_q.push_back({exp_res, ill ? 5'b0 : fexc, ill, tag});
      if (!ill) begin
         check("fpu_instr", bus.fpu_instr, exp_instr);
         check("fpu_op1",   bus.fpu_op1,   exp_op1);
         check("fpu_op2",   bus.fpu_op2,   exp_op2);
         check("fpu_op3",   bus.fpu_op3,   exp_op3);
         check("state_exec", state, 2'd1);
         last_instr = exp_instr;
      end else begin
         check("instr_kept", bus.fpu_instr, last_instr);
      end
      n = 0;
      while (!bus.resp_valid && n < 40) begin
         if (clr_cap && n == LAT) bus.fflags_clr = 1'b1;
         @(posedge clk); #1;
         bus.fflags_clr = 1'b0;
         n++;
      end
      check("resp_latency", n, ill ? 0 : LAT + 1);
      if (!ill) check("instr_stable", bus.fpu_instr, exp_instr);
      for (int i = 0; i < bp; i++) begin
         check("bp_resp_valid",  bus.resp_valid,  1'b1);
         check("bp_req_ready",   bus.req_ready,   1'b0);
         check("bp_resp_result", bus.resp_result, exp_res);
         check("bp_resp_tag",    bus.resp_tag,    tag);
         bus.req_valid = 1'b1;
         @(posedge clk); #1;
      end
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("post_hs_state", state, 2'd0);
      check("post_hs_valid", bus.resp_valid, 1'b0);
      check("fflags", bus.fflags, exp_fflags);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      bus.req_valid = 0; bus.req_op = 0; bus.req_rm = 0; bus.req_a = 0; bus.req_b = 0;
      bus.req_c = 0; bus.req_tag = 0; bus.frm = 0; bus.fflags_clr = 0;
      bus.fpu_result = 0; bus.fpu_excep = 0; bus.resp_ready = 1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_fpu_instr",  bus.fpu_instr,  32'h0);
      check("rst_resp_valid", bus.resp_valid, 1'b0);
      check("rst_fflags",     bus.fflags,     5'h0);
      check("rst_req_ready",  bus.req_ready,  1'b1);
      rst = 1'b0;

      // op rm a b c tag fres fexc instr op1 op2 op3 ill res fflags bp clr
      issue(ADD,  3'b001, 32'hFFFF_3E00, 32'h3E00, 32'h1111, 4'd3, 32'h4000, 5'b00000,
            32'h04209053, 32'h3E00, 32'h3E00, 32'h0, 1'b0, 32'h4000, 5'b00000, 0, 1'b0);
      issue(DIV,  3'b000, 32'h3C00, 32'h0000, 32'h0, 4'd5, 32'h7C00, 5'b01000,
            32'h1C208053, 32'h3C00, 32'h0000, 32'h0, 1'b0, 32'h7C00, 5'b01000, 0, 1'b0);
      issue(MUL,  3'b000, 32'h3555, 32'h3555, 32'h0, 4'd6, 32'h3456, 5'b00001,
            32'h14208053, 32'h3555, 32'h3555, 32'h0, 1'b0, 32'h3456, 5'b01001, 0, 1'b0);
      issue(SUB,  3'b000, 32'h4000, 32'h3C00, 32'h0, 4'd7, 32'h3C00, 5'b00001,
            32'h0C208053, 32'h4000, 32'h3C00, 32'h0, 1'b0, 32'h3C00, 5'b00001, 0, 1'b1);
      issue(MADD, 3'b010, 32'h3C00, 32'h4000, 32'h4200, 4'd8, 32'h4400, 5'b00000,
            32'h1C20A043, 32'h3C00, 32'h4000, 32'h4200, 1'b0, 32'h4400, 5'b00001, 0, 1'b0);
      issue(SGNJX, 3'b001, 32'h3C00, 32'hBC00, 32'h0, 4'd9, 32'hBC00, 5'b00000,
            32'h2420A053, 32'h3C00, 32'hBC00, 32'h0, 1'b0, 32'hBC00, 5'b00001, 5, 1'b0);
      issue(LT,   3'b100, 32'h3C00, 32'h4000, 32'h0, 4'd10, 32'h0001, 5'b00000,
            32'hA4209053, 32'h3C00, 32'h4000, 32'h0, 1'b0, 32'h0001, 5'b00001, 0, 1'b0);
      bus.frm = 3'b011;
      issue(CVT_I2F, 3'b111, 32'h1234_5678, 32'h9999, 32'h0, 4'd11, 32'h4D91, 5'b00001,
            32'hD420B053, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 32'h4D91, 5'b00001, 0, 1'b0);
      issue(ADD,  3'b101, 32'h3C00, 32'h3C00, 32'h0, 4'd12, 32'h5555, 5'b11111,
            32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 5'b00001, 0, 1'b0);
      bus.frm = 3'b110;
      issue(MUL,  3'b111, 32'h3C00, 32'h3C00, 32'h0, 4'd13, 32'h5555, 5'b11111,
            32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 5'b00001, 0, 1'b0);
      bus.frm = 3'b000;
      issue(5'd17, 3'b000, 32'h3C00, 32'h3C00, 32'h0, 4'd14, 32'h5555, 5'b11111,
            32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 5'b00001, 0, 1'b0);
      issue(SQRT, 3'b000, 32'hBE00, 32'h3C00, 32'h0, 4'd15, 32'h1234, 5'b10000,
            32'h5C208053, 32'hBE00, 32'h0, 32'h0, 1'b0, SQRT_EXP, 5'b10001, 0, 1'b0);

      // Reset while a transaction is in EXEC: it is dropped without a response.
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_op = ADD; bus.req_rm = 3'b000; bus.req_tag = 4'd2;
      bus.req_a = 32'h3C00; bus.req_b = 32'h3C00;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("pre_rst_state", state, 2'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_state",       state,            2'd0);
      check("mid_rst_fpu_instr",   bus.fpu_instr,    32'h0);
      check("mid_rst_fpu_op1",     bus.fpu_op1,      32'h0);
      check("mid_rst_resp_valid",  bus.resp_valid,   1'b0);
      check("mid_rst_resp_result", bus.resp_result,  32'h0);
      check("mid_rst_resp_tag",    bus.resp_tag,     4'h0);
      check("mid_rst_fflags",      bus.fflags,       5'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("post_rst_no_resp", bus.resp_valid, 1'b0);
      end
      check("post_rst_req_ready", bus.req_ready, 1'b1);
      check("exp_q_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/dl_fpu_issue_ctrl.md
Name: dl_fpu_issue_ctrl

Overview:
Command-side counterpart of the DLFloat16 FPU top. It accepts abstract operation requests over a valid/ready interface and encodes them into the 32-bit OP-FP instruction word that the FPU's instruction decoder consumes. It drives the operand buses, waits the FPU latency, then captures the result and the exception flags. Responses return over valid/ready with a tag; the block also maintains the sticky fflags register. Single outstanding transaction.

Parameters:
LATENCY, 1, cycles from stable fpu_instr/fpu_op* to a valid fpu_result/fpu_excep (1..15).
TAG_W, 4, width of the request/response tag.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request ready
req_op  in  5  operation code (package enum)
req_rm  in  3  rounding mode; 3'b111 = dynamic
req_a, req_b, req_c  in  32  operands; FP ops use [15:0], CVT_I2F uses req_a[31:0]
req_tag  in  TAG_W  transaction tag
frm  in  3  dynamic rounding mode
fflags_clr  in  1  clear sticky flags
fpu_instr  out  32  encoded instruction to FPU
fpu_op1, fpu_op2, fpu_op3  out  32  operands to FPU
fpu_result  in  32  FPU result
fpu_excep  in  5  {invalid, div_by_zero, overflow, underflow, inexact}
resp_valid  out  1  response valid
resp_ready  in  1  response ready
resp_result  out  32  captured result
resp_flags  out  5  flags of this op
resp_illegal  out  1  request was not encodable
resp_tag  out  TAG_W  echoed tag
fflags  out  5  sticky OR of all completed flags

Behaviour:
- Reset (async, any state): state IDLE; all registered outputs 0 (fpu_instr, fpu_op*, resp_*, fflags). req_ready = (state==IDLE), so it reads 1 once rst deasserts. An in-flight transaction is dropped and no response is produced.
- States: IDLE, EXEC, RESP.
- IDLE: on req_valid&&req_ready, latch tag and resolve rm (3'b111 -> frm).
  - Illegal if: op > CVT_F2I, resolved rm is 101/110, or DYN with frm >= 101. Illegal -> RESP with resp_illegal=1, result 0, flags 0; fpu_* unchanged.
  - Otherwise -> EXEC: load fpu_instr, fpu_op1..3 (unused operands driven 0), counter=LATENCY.
- Encoding, R-type: [31:27] funct5, [26:25] fmt=2'b10, [24:20] rs2=2, [19:15] rs1=1, [14:12] rm, [11:7] rd=0, [6:0] 7'b1010011.
  - MADD/MSUB: R4 form, [31:27] rs3=3, opcode 1000011/1000111.
  - SGNJ/N/X, MIN/MAX and EQ/LT/LE place the sub-select in [14:12] instead of rm.
- EXEC: counter decrements each cycle. At the edge where it reaches 0, capture fpu_result/fpu_excep into resp_result/resp_flags and move to RESP. fpu_* stay stable throughout EXEC.
- Latency: resp_valid rises LATENCY+1 cycles after the accept edge.
- RESP: hold resp_* stable while resp_valid && !resp_ready. On handshake -> IDLE. No new request is accepted in the same cycle.
- fflags: updates once, at the capture edge. next = (fflags_clr ? 0 : fflags) | new_flags. Illegal responses contribute 0. fflags_clr alone clears.

Optional Feature:
DL_FPU_CANON_NAN_EN
- Defined: any captured result with invalid=1 is replaced by canonical DLFloat16 NaN 32'h0000_7FFF; flags are unchanged.
- Undefined: fpu_result passes through unmodified.

Decomposition:
- Package dl_fpu_pkg holds:
  - op enum: ADD, SUB, MUL, DIV, SQRT, MADD, MSUB, SGNJ, SGNJN, SGNJX, MIN, MAX, EQ, LT, LE, CVT_I2F, CVT_F2I
  - funct5 and opcode constants, fmt constant, rm constants (RNE..RMM, DYN)
  - flag bit indices, canonical NaN constant
- One sub-module, dl_fpu_instr_enc: combinational op + rm -> {instr, illegal}. It is reused by the decoder testbench.

Test Plan:
- ADD, rm=001, a=16'h3E00, b=16'h3E00, model returns 16'h4000 -> fpu_instr=32'h04209053; resp_result=32'h4000, resp_flags=0, tag echoed, resp_valid at accept+2 (LATENCY=1).
- DIV by zero, model excep=5'b01000 -> resp_flags=01000, fflags=01000. Then an inexact op -> fflags=01001. Pulse fflags_clr during a capture of 00001 -> fflags=00001.
- req_rm=101, or DYN with frm=110 -> resp_illegal=1, resp_result=0, fflags unchanged, fpu_instr not updated.
- Backpressure: resp_ready=0 for 5 cycles -> resp_* stable and req_ready=0 throughout; accept only after the handshake.
- rst asserted mid-EXEC -> next cycle all outputs 0, no resp_valid, req_ready=1 after release.
- With DL_FPU_CANON_NAN_EN: SQRT of 16'hBE00, model result 16'h1234 with invalid=1 -> resp_result=32'h7FFF.
